// File: rtl/fp_normalizer_pkg.sv
// Shared FPU constants and the beat record carried between the normaliser pipeline stages.
package fpu_pkg;

   localparam int unsigned MANT_W = 32;
   localparam int unsigned IDX_W  = $clog2(MANT_W);
   localparam int unsigned EXP_W  = 8;

   typedef struct packed {
      logic [MANT_W-1:0] mant;
      logic [EXP_W-1:0]  exp;
      logic [IDX_W-1:0]  sh;
      logic              zero;
      logic              err;
   } norm_beat_t;

   typedef struct packed {
      logic [MANT_W-1:0] mant;
      logic [EXP_W-1:0]  exp;
      logic              zero;
      logic              uf;
      logic              err;
   } norm_out_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// Valid/ready bundle for the normaliser: upstream beat in, normalised beat out.
interface fp_normalizer_if;
   import fpu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [MANT_W-1:0] in_mant;
   logic [IDX_W-1:0]  in_index;
   logic [EXP_W-1:0]  in_exp;
   logic              out_valid;
   logic              out_ready;
   logic [MANT_W-1:0] out_mant;
   logic [EXP_W-1:0]  out_exp;
   logic              out_zero;
   logic              out_uf;
   logic              out_err;

   modport master (
      output in_valid, in_mant, in_index, in_exp, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uf, out_err
   );

   modport slave (
      input  in_valid, in_mant, in_index, in_exp, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_zero, out_uf, out_err
   );

endinterface

// File: rtl/fp_normalizer_decoder.sv
// Turns the encoder's leading-one index into a shift amount and checks it against the mantissa.
module lzd_index_decoder
   import fpu_pkg::*;
(
   input  logic [MANT_W-1:0] mant,
   input  logic [IDX_W-1:0]  index,
   output logic [IDX_W-1:0]  sh,
   output logic              zero,
   output logic              err
);

   logic [MANT_W-1:0] onehot;
   logic [MANT_W-1:0] at_or_below;

   always_comb begin
      onehot      = MANT_W'(1) << index;
      // For the top index onehot<<1 wraps to 0, so the mask becomes all ones as intended.
      at_or_below = (onehot << 1) - MANT_W'(1);
      sh          = IDX_W'(MANT_W - 1) - index;
      zero        = (mant == '0);
      err         = !zero && (((mant & onehot) == '0) || ((mant & ~at_or_below) != '0));
   end

endmodule

// File: rtl/fp_normalizer.sv
// Two-stage valid/ready normaliser: decode/check the leading-one index, then shift and adjust exponent.
module fp_normalizer
   import fpu_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   fp_normalizer_if.slave  bus
);

   logic       adv1;
   logic       adv2;
   logic       s1_valid_d, s1_valid_q;
   logic       s2_valid_d, s2_valid_q;
   norm_beat_t s1_beat_d,  s1_beat_q;
   norm_out_t  s2_out_d,   s2_out_q;

   logic [IDX_W-1:0] dec_sh;
   logic             dec_zero;
   logic             dec_err;

   lzd_index_decoder u_decoder (
      .mant  (bus.in_mant),
      .index (bus.in_index),
      .sh    (dec_sh),
      .zero  (dec_zero),
      .err   (dec_err)
   );

   always_comb begin
      adv2 = !s2_valid_q || bus.out_ready;
      adv1 = !s1_valid_q || adv2;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_beat_d  = s1_beat_q;
      if (adv1) begin
         s1_valid_d     = bus.in_valid;
         s1_beat_d.mant = bus.in_mant;
         s1_beat_d.exp  = bus.in_exp;
         s1_beat_d.sh   = dec_sh;
         s1_beat_d.zero = dec_zero;
         s1_beat_d.err  = dec_err;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_out_d   = s2_out_q;
      if (adv2) begin
         s2_valid_d   = s1_valid_q;
         s2_out_d.err = s1_beat_q.err;
         s2_out_d.zero = 1'b0;
         s2_out_d.uf   = 1'b0;
         if (s1_beat_q.zero) begin
            s2_out_d.mant = '0;
            s2_out_d.exp  = '0;
            s2_out_d.zero = 1'b1;
            s2_out_d.err  = 1'b0;
         end else if (s1_beat_q.exp < EXP_W'(s1_beat_q.sh)) begin
            s2_out_d.mant = '0;
            s2_out_d.exp  = '0;
            s2_out_d.uf   = 1'b1;
         end else begin
            s2_out_d.mant = s1_beat_q.mant << s1_beat_q.sh;
            s2_out_d.exp  = s1_beat_q.exp - EXP_W'(s1_beat_q.sh);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_beat_q  <= '0;
         s2_out_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_beat_q  <= s1_beat_d;
         s2_out_q   <= s2_out_d;
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_mant  = s2_out_q.mant;
   assign bus.out_exp   = s2_out_q.exp;
   assign bus.out_zero  = s2_out_q.zero;
   assign bus.out_uf    = s2_out_q.uf;
   assign bus.out_err   = s2_out_q.err;

endmodule
